// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// The state encoding is fixed so checkers and the debug port can decode it.
package bin2bcd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Largest value representable in the given number of decimal digits.
    function automatic int max_val(input int digits);
        int p;
        p = 1;
        for (int i = 0; i < digits; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit correction: a nibble of 5 or more gets +3 before the
// shift so that the doubled value carries correctly into the next digit.
module bin2bcd_seq_add3 (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Handshake: start is sampled only in IDLE; busy covers SHIFT and DONE; done
// pulses for one cycle when bcd/ovf update, and start may be accepted then.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_W-1:0]      bin,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output state_t                dbg_state
);

    localparam int                 BCD_W   = 4 * DIGITS;
    localparam int                 CNT_W   = $clog2(BIN_W + 1);
    localparam logic [BIN_W-1:0]   MAX_BIN = BIN_W'(max_val(DIGITS));
    localparam logic [BCD_W-1:0]   ALL9    = {DIGITS{4'h9}};
    localparam logic [CNT_W-1:0]   LAST    = CNT_W'(BIN_W - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic                w_busy;
    logic [BIN_W-1:0]    r_shreg;
    logic [BCD_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ovf_pend;
    logic [BCD_W-1:0]    r_bcd;
    logic                r_ovf;
    logic                r_done;
    logic [BCD_W-1:0]    w_adj;
    logic [BCD_W-1:0]    w_acc_shift;
    logic                w_last;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_add3
            bin2bcd_seq_add3 u_add3 (
                .i_nib (r_acc[4*g +: 4]),
                .o_nib (w_adj[4*g +: 4])
            );
        end
    endgenerate

    assign w_acc_shift = {w_adj[BCD_W-2:0], r_shreg[BIN_W-1]};
    assign w_last      = (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_busy       = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg    <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_bcd      <= '0;
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shreg    <= bin;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_ovf_pend <= (bin > MAX_BIN);
                    end
                end
                SHIFT: begin
                    r_acc   <= w_acc_shift;
                    r_shreg <= {r_shreg[BIN_W-2:0], 1'b0};
                    r_cnt   <= r_cnt + CNT_W'(1);
                    // A bit leaving the top digit can only happen on overflow.
                    r_ovf_pend <= r_ovf_pend | w_adj[BCD_W-1];
                end
                DONE: begin
                    r_bcd  <= r_ovf_pend ? ALL9 : r_acc;
                    r_ovf  <= r_ovf_pend;
                    r_done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = w_busy;
    assign done      = r_done;
    assign bcd       = r_bcd;
    assign ovf       = r_ovf;
    assign dbg_state = r_state;

endmodule
